// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N:1 mux: parameter bounds,
// index-width helper and the packet-lock state encoding.
package mux_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  localparam int W_MIN = 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: search starts at ptr, wraps
// modulo N, and yields a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_bin
);

  logic          found;
  logic [IW:0]   pos;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_bin = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // one extra bit so ptr+i cannot overflow before the wrap
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      idx = pos[IW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_bin  = idx;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// N-input registered mux with round-robin arbitration and valid/ready.
// Optional packet lock on in_last: define MUX_N_1_RR_LAST_LOCK_EN.
//
// state       | meaning
// ST_UNLOCKED | every beat re-arbitrates across all valid channels
// ST_LOCKED   | mid-packet; only lock_ch is eligible, ptr frozen
module mux_n_1_rr
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N*W-1:0]        in_data,
  input  logic [N-1:0]          in_valid,
  input  logic [N-1:0]          in_last,
  output logic [N-1:0]          in_ready,
  output logic [W-1:0]          y,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [idx_w(N)-1:0]   gnt_idx
);

  localparam int  IW       = idx_w(N);
  localparam bit  PARAM_OK = (N >= N_MIN) && (N <= N_MAX) && (W >= W_MIN);

  if (!PARAM_OK) begin : g_param_check
    $error("mux_n_1_rr: N must be 2..16 and W >= 1");
  end

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_bin;
  logic [IW-1:0] gnt_inc;
  logic [W-1:0]  win_data;
  logic          load;
  logic          en;
  logic          accept;

  assign load    = !y_valid || y_ready;
  // reset also blocks acceptance so no beat slips in during the reset cycle
  assign en      = load && rst_n;
  assign accept  = |gnt;
  assign in_ready = gnt;
  assign gnt_inc = (gnt_bin == IW'(N-1)) ? '0 : gnt_bin + IW'(1);

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .en      (en),
    .gnt     (gnt),
    .gnt_bin (gnt_bin)
  );

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) win_data = in_data[k*W +: W];
    end
  end

`ifdef MUX_N_1_RR_LAST_LOCK_EN
  lock_state_t   state, state_nxt;
  logic [IW-1:0] lock_ch, lock_ch_nxt;
  logic [N-1:0]  lock_mask;

  assign lock_mask = {{(N-1){1'b0}}, 1'b1} << lock_ch;
  assign req       = (state == ST_LOCKED) ? (in_valid & lock_mask) : in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_UNLOCKED;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    ptr_nxt     = gnt_inc;
    case (state)
      ST_UNLOCKED: begin
        if (accept && !in_last[gnt_bin]) begin
          state_nxt   = ST_LOCKED;
          lock_ch_nxt = gnt_bin;
          ptr_nxt     = ptr;
        end
      end
      ST_LOCKED: begin
        ptr_nxt = ptr;
        if (accept && in_last[gnt_bin]) begin
          state_nxt = ST_UNLOCKED;
          ptr_nxt   = gnt_inc;
        end
      end
      default: state_nxt = ST_UNLOCKED;
    endcase
  end
`else
  logic unused_last;

  assign unused_last = ^in_last;
  assign req         = in_valid;
  assign ptr_nxt     = gnt_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else if (accept) begin
      y       <= win_data;
      y_valid <= 1'b1;
      gnt_idx <= gnt_bin;
      ptr     <= ptr_nxt;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Directed bench for mux_n_1_rr (N=4, W=8); expectations are hand-derived
// and switch with MUX_N_1_RR_LAST_LOCK_EN for the packet-lock scenarios.
module tb_mux_n_1_rr;

  localparam int N = 4;
  localparam int W = 8;
`ifdef MUX_N_1_RR_LAST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [1:0]     gnt_idx;
  logic [W-1:0]   ch_data [N];

  int n_run  = 0;
  int n_fail = 0;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  always #5 clk = ~clk;

  mux_n_1_rr #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .gnt_idx  (gnt_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g [4];
  logic [7:0] exp_d [4];
  logic [3:0] exp_r;
  logic       took2;
  int         cnt;

  initial begin
    rst_n      = 1'b0;
    y_ready    = 1'b1;
    in_valid   = 4'b1111;
    in_last    = 4'b1111;
    ch_data[0] = 8'h00;
    ch_data[1] = 8'h11;
    ch_data[2] = 8'h22;
    ch_data[3] = 8'h33;

    // reset with every channel requesting
    step();
    step();
    check_eq("rst_y", y, 0);
    check_eq("rst_y_valid", y_valid, 0);
    check_eq("rst_gnt_idx", gnt_idx, 0);
    check_eq("rst_in_ready", in_ready, 0);

    // rotation: 00,11,22,33,00 with no bubbles
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("rot_in_ready", in_ready, 32'(4'b0001 << (i % 4)));
      step();
      check_eq("rot_y", y, 32'(8'h11 * (i % 4)));
      check_eq("rot_gnt_idx", gnt_idx, 32'(i % 4));
      check_eq("rot_y_valid", y_valid, 1);
    end

    // backpressure for 3 cycles holding beat 0x00
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready", in_ready, 0);
      step();
      check_eq("bp_y", y, 8'h00);
      check_eq("bp_gnt_idx", gnt_idx, 0);
      check_eq("bp_y_valid", y_valid, 1);
    end
    y_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", in_ready, 4'b0010);
    step();
    check_eq("bp_release_y", y, 8'h11);
    check_eq("bp_release_y_valid", y_valid, 1);

    // sparse: channels 1 and 3, ptr now 2 -> 3,1,3
    in_valid = 4'b1010;
    #1;
    check_eq("sp0_in_ready", in_ready, 4'b1000);
    step();
    check_eq("sp0_y", y, 8'h33);
    check_eq("sp0_gnt_idx", gnt_idx, 3);
    #1;
    check_eq("sp1_in_ready", in_ready, 4'b0010);
    step();
    check_eq("sp1_y", y, 8'h11);
    check_eq("sp1_gnt_idx", gnt_idx, 1);
    step();
    check_eq("sp2_y", y, 8'h33);
    check_eq("sp2_gnt_idx", gnt_idx, 3);

    // drain with no requests: y_valid drops, y/gnt_idx retained
    in_valid = 4'b0000;
    #1;
    check_eq("drain_in_ready", in_ready, 0);
    step();
    check_eq("drain_y_valid", y_valid, 0);
    check_eq("drain_y", y, 8'h33);
    check_eq("drain_gnt_idx", gnt_idx, 3);

    // single-beat packet from channel 1 moves ptr to 2
    in_valid = 4'b0010;
    step();
    check_eq("pre_lock_gnt_idx", gnt_idx, 1);

    // channel 2 sends a 3-beat packet while channel 0 stays valid
    ch_data[0] = 8'hC0;
    if (LOCK) begin
      exp_g = '{2'd2, 2'd2, 2'd2, 2'd0};
      exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hC0};
    end else begin
      exp_g = '{2'd2, 2'd0, 2'd2, 2'd0};
      exp_d = '{8'hA0, 8'hC0, 8'hA1, 8'hC0};
    end
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      ch_data[2]  = 8'hA0 + 8'(cnt);
      in_last[2]  = (cnt == 2);
      in_valid[2] = (cnt < 3);
      in_valid[0] = 1'b1;
      in_valid[1] = 1'b0;
      in_valid[3] = 1'b0;
      #1;
      exp_r = 4'b0001 << exp_g[b];
      check_eq("pkt_in_ready", in_ready, exp_r);
      took2 = in_ready[2];
      step();
      if (took2) cnt++;
      check_eq("pkt_gnt_idx", gnt_idx, exp_g[b]);
      check_eq("pkt_y", y, exp_d[b]);
    end
    in_valid = 4'b0000;
    step();
    check_eq("pkt_drain_y_valid", y_valid, 0);

    // reset in the middle of a packet on channel 2 (ptr is 1 here)
    ch_data[2] = 8'hA0;
    in_last[2] = 1'b0;
    in_valid   = 4'b0100;
    #1;
    check_eq("mid_in_ready", in_ready, 4'b0100);
    step();
    check_eq("mid_y", y, 8'hA0);
    check_eq("mid_gnt_idx", gnt_idx, 2);
    in_valid = 4'b0001;
    #1;
    check_eq("mid_lock_block", in_ready, LOCK ? 4'b0000 : 4'b0001);
    rst_n    = 1'b0;
    in_valid = 4'b0101;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 0);
    step();
    check_eq("mid_rst_y_valid", y_valid, 0);
    check_eq("mid_rst_y", y, 0);
    check_eq("mid_rst_gnt_idx", gnt_idx, 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 4'b0001);
    step();
    check_eq("post_rst_y", y, 8'hC0);
    check_eq("post_rst_gnt_idx", gnt_idx, 0);
    check_eq("post_rst_y_valid", y_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_1_rr.md
# mux_n_1_rr

Parametrised N-input, W-bit registered multiplexer with round-robin arbitration and valid/ready handshakes. It replaces fixed-select 2:1 muxing wherever several producers share one consumer. Sources present data with `in_valid`; the block grants one source per accepted beat, registers the winning word, and presents it downstream with `y_valid`. It sits between multiple producer blocks and a single downstream sink.

## Interface
Parameters:
- `N`, 4, number of input channels, 2..16.
- `W`, 8, data width per channel, ≥1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: synchronous reset, active-low, sampled on `clk` rising edge.
- `in_data` in N*W: channel k occupies bits [k*W +: W].
- `in_valid` in N: per-channel data valid.
- `in_last` in N: per-channel end-of-packet marker. Used only with the lock feature; otherwise ignored.
- `in_ready` out N: per-channel accept. One-hot or zero.
- `y` out W: registered output data.
- `y_valid` out 1: output register holds a beat.
- `y_ready` in 1: downstream accept.
- `gnt_idx` out $clog2(N): channel index of the beat currently in `y`.

## Operation
- Output register load condition: `load = !y_valid || y_ready`.
- Eligible set when `load = 1`: channels with `in_valid = 1`, restricted to the locked channel when a lock is active.
- Winner selection:
  - Priority is rotating: the search starts at `ptr` and wraps modulo N.
  - `in_ready[winner] = 1`; every other channel's `in_ready = 0`.
  - `in_ready` is all-zero when `load = 0` or the eligible set is empty.
- On each accept (load with a winner):
  - `y <= in_data[winner]`
  - `y_valid <= 1`
  - `gnt_idx <= winner`
  - `ptr <= (winner+1) mod N`, except while a lock is held (see Configuration).
- When `y_ready = 1`, `y_valid = 1`, and there is no winner: `y_valid <= 0`. `y` and `gnt_idx` keep their last value.
- Simultaneous drain and accept in one cycle: the register reloads and `y_valid` stays 1. No bubble occurs.
- `in_ready` depends combinationally on `in_valid`. Sources must not make `in_valid` depend on `in_ready`.
- Reset values: `y = 0`, `y_valid = 0`, `gnt_idx = 0`, `ptr = 0`, lock cleared, `in_ready = 0`.
- Reset mid-operation: any held beat is discarded and any lock is dropped. Nothing is accepted in the reset cycle.

## Timing
- Latency: 1 cycle from accept (`in_valid & in_ready`) to the data appearing on `y` with `y_valid = 1`.
- Throughput: one beat per cycle while `y_ready = 1`.
- Fairness with all N channels continuously valid: grants rotate 0,1,…,N-1,0… Each channel waits at most N-1 beats.
- `in_ready` is combinational from `in_valid`, `y_valid`, `y_ready`, `ptr`, and lock state.
- All registered outputs change only on the `clk` rising edge.
- Stall: while `y_valid = 1` and `y_ready = 0`:
  - `y`, `gnt_idx`, and `ptr` are stable.
  - All `in_ready` bits are 0.

## Configuration
- Macro: `MUX_N_1_RR_LAST_LOCK_EN`.
- Defined (packet lock):
  - Accepting a beat with `in_last[winner] = 0` sets the lock on `winner`.
  - While locked, only that channel is eligible, and `ptr` does not advance.
  - Accepting a beat from the locked channel with `in_last = 1` clears the lock and sets `ptr <= winner+1`.
  - A single-beat packet (`in_last = 1` on its first beat) never locks.
  - Two-state FSM: UNLOCKED → LOCKED on accept with `in_last = 0`; LOCKED → UNLOCKED on accept of the locked channel with `in_last = 1`; reset → UNLOCKED.
- Undefined: `in_last` is ignored, the FSM is absent, and every beat re-arbitrates.

## Structure
- Shared package `mux_pkg`:
  - Index-width helper constant/function for `$clog2(N)`.
  - Parameter range bounds (N 2..16, W ≥ 1).
- Sub-module `rr_arbiter`: inputs `req[N]`, `ptr`, `en`; outputs one-hot `gnt[N]` and binary `gnt_bin`. Purely combinational.
- The top level holds the output register, `ptr`, and the lock FSM.

## Test plan
- Reset: drive `rst_n = 0` for 2 cycles with all `in_valid = 1` → `y = 0`, `y_valid = 0`, `gnt_idx = 0`, `in_ready = 0`. First grant after release goes to channel 0.
- Rotation: N=4, all valid, `y_ready = 1`, `in_data` = {0x33, 0x22, 0x11, 0x00} → `y` sequence 0x00, 0x11, 0x22, 0x33, 0x00 with no bubbles. `gnt_idx` follows 0,1,2,3,0.
- Sparse requests: only channels 1 and 3 valid, `ptr = 2` → channel 3 granted first, then 1, then 3.
- Backpressure: hold `y_ready = 0` for 3 cycles while `y_valid = 1` → `y` and `gnt_idx` stable, `in_ready = 0`. Releasing `y_ready` with new requests pending → reload in the same cycle, `y_valid` stays 1.
- Lock (macro defined):
  - Stimulus: channel 2 sends 3 beats with `in_last` = 0,0,1 while channel 0 is valid throughout.
  - Expected: all 3 channel-2 beats are output consecutively, then channel 0 is granted.
  - Repeat with the macro undefined → channel 0 beats are interleaved with the channel-2 beats.
- Reset mid-packet (macro defined): assert `rst_n = 0` after the first beat of a locked packet → lock cleared and `y_valid = 0`. The next grant follows rotation from 0.
